fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle datapath and replaces its direct combinational instruction-memory lookup. It issues word fetches to instruction memory over a req/ack handshake and buffers the returned instructions with their PCs in a small FIFO. It presents them to the datapath through a valid/ready interface. A taken branch from the datapath redirects fetch, flushes the FIFO and discards any in-flight response.

---
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding req/ack fetch at a time, with responses buffered
// in a small PC/instruction FIFO and handed to the datapath over a valid/ready interface.
module fetch_unit #(
  parameter int unsigned BITSIZE = 32,
  parameter int unsigned DEPTH = 4,
  parameter logic [BITSIZE-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [BITSIZE-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [BITSIZE-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [BITSIZE-1:0] redirect_pc,
  output logic               ins_valid,
  output logic [BITSIZE-1:0] ins,
  output logic [BITSIZE-1:0] ins_pc,
  input  logic               ins_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

  state_e             state_q, state_d;
  logic [BITSIZE-1:0] req_addr_q, req_addr_d;
  logic [BITSIZE-1:0] next_pc_q, next_pc_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [BITSIZE-1:0] pc_mem_q  [DEPTH];
  logic [BITSIZE-1:0] ins_mem_q [DEPTH];

  logic               push;
  logic               pop;
  logic               flush;
  logic [BITSIZE-1:0] drop_target;

  assign imem_req  = (state_q != IDLE);
  assign imem_addr = req_addr_q;
  assign ins_valid = (count_q != '0);
  assign ins       = ins_mem_q[rd_ptr_q];
  assign ins_pc    = pc_mem_q[rd_ptr_q];

  assign pop         = ins_valid & ins_ready;
  assign push        = (state_q == REQ) & imem_ack & ~redirect;
  assign drop_target = redirect ? redirect_pc : next_pc_q;

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    next_pc_d  = next_pc_q;
    flush      = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          flush     = 1'b1;
          next_pc_d = redirect_pc;
        end else if (count_q < DEPTH_C) begin
          req_addr_d = next_pc_q;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          // Without an ack the old response is still coming and must be swallowed in DROP
          flush     = 1'b1;
          next_pc_d = redirect_pc;
          state_d   = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          next_pc_d = req_addr_q + BITSIZE'(4);
          if ((count_q + CW'(1) - CW'(pop)) < DEPTH_C) begin
            req_addr_d = req_addr_q + BITSIZE'(4);
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (imem_ack) begin
          req_addr_d = drop_target;
          next_pc_d  = drop_target;
          state_d    = REQ;
        end else if (redirect) begin
          next_pc_d = redirect_pc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      req_addr_q <= RESET_PC;
      next_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      next_pc_q  <= next_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset; an entry is only visible once count says so
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      pc_mem_q[wr_ptr_q]  <= req_addr_q;
      ins_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for streaming/backpressure plus
// hand-written sequences for wait states, redirects and mid-stream reset.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        insValid;
  logic [31:0] ins;
  logic [31:0] insPc;
  logic        insReady;

  int checks = 0;
  int errors = 0;
  int waitCycles = 0;
  int waitCnt = 0;
  bit holdAck = 1'b0;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
  } vec_t;

  vec_t vecs[$];

  fetch_unit #(.BITSIZE(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock(clock),
    .reset(reset),
    .imem_req(imemReq),
    .imem_addr(imemAddr),
    .imem_ack(imemAck),
    .imem_rdata(imemRdata),
    .redirect(redirect),
    .redirect_pc(redirectPc),
    .ins_valid(insValid),
    .ins(ins),
    .ins_pc(insPc),
    .ins_ready(insReady)
  );

  always #5 clock = ~clock;

  // Advance one cycle, then let the memory model answer the request now visible
  task automatic tick();
    @(posedge clock);
    #1;
    if (!imemReq) begin
      imemAck = 1'b0;
      waitCnt = 0;
    end else if (holdAck) begin
      imemAck = 1'b0;
    end else if (waitCnt >= waitCycles) begin
      imemAck = 1'b1;
      waitCnt = 0;
    end else begin
      imemAck = 1'b0;
      waitCnt++;
    end
    imemRdata = imemAddr ^ 32'hA5A5_0000;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkCycle(input string tag, input logic eReq, input logic [31:0] eAddr,
                            input logic eValid, input logic [31:0] ePc);
    checkOutput({tag, " imem_req"}, 32'(imemReq), 32'(eReq));
    checkOutput({tag, " imem_addr"}, imemAddr, eAddr);
    checkOutput({tag, " ins_valid"}, 32'(insValid), 32'(eValid));
    if (eValid) begin
      checkOutput({tag, " ins_pc"}, insPc, ePc);
      checkOutput({tag, " ins"}, ins, ePc ^ 32'hA5A5_0000);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset    = v.rst;
    insReady = v.ready;
    tick();
  endtask

  task automatic doReset();
    reset    = 1'b1;
    redirect = 1'b0;
    holdAck  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    redirect   = 1'b0;
    redirectPc = 32'h0;
    insReady   = 1'b1;
    imemAck    = 1'b0;
    imemRdata  = 32'h0;

    // Zero-wait streaming, then reset mid-request followed by a fill/drain with ready low
    vecs.push_back('{1, 1, 0, 32'h00, 0, 32'h00});
    vecs.push_back('{1, 1, 0, 32'h00, 0, 32'h00});
    vecs.push_back('{0, 1, 1, 32'h00, 0, 32'h00});
    vecs.push_back('{0, 1, 1, 32'h04, 1, 32'h00});
    vecs.push_back('{0, 1, 1, 32'h08, 1, 32'h04});
    vecs.push_back('{0, 1, 1, 32'h0C, 1, 32'h08});
    vecs.push_back('{0, 1, 1, 32'h10, 1, 32'h0C});
    vecs.push_back('{1, 0, 0, 32'h00, 0, 32'h00});
    vecs.push_back('{0, 0, 1, 32'h00, 0, 32'h00});
    vecs.push_back('{0, 0, 1, 32'h04, 1, 32'h00});
    vecs.push_back('{0, 0, 1, 32'h08, 1, 32'h00});
    vecs.push_back('{0, 0, 1, 32'h0C, 1, 32'h00});
    vecs.push_back('{0, 0, 0, 32'h0C, 1, 32'h00});
    vecs.push_back('{0, 0, 0, 32'h0C, 1, 32'h00});
    vecs.push_back('{0, 1, 0, 32'h0C, 1, 32'h04});
    vecs.push_back('{0, 1, 1, 32'h10, 1, 32'h08});
    vecs.push_back('{0, 1, 1, 32'h14, 1, 32'h0C});
    vecs.push_back('{0, 1, 1, 32'h18, 1, 32'h10});
    vecs.push_back('{0, 1, 1, 32'h1C, 1, 32'h14});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkCycle($sformatf("vec%0d", i), vecs[i].expReq, vecs[i].expAddr,
                 vecs[i].expValid, vecs[i].expPc);
    end

    // Three wait cycles per ack: address held four cycles, each word shows up once
    waitCycles = 3;
    insReady   = 1'b1;
    doReset();
    for (int c = 1; c <= 24; c++) begin
      tick();
      checkCycle($sformatf("wait c%0d", c), 1'b1, 32'(4 * ((c - 1) / 4)),
                 (c >= 5) && ((c - 5) % 4 == 0), 32'(4 * ((c - 5) / 4)));
    end
    waitCycles = 0;

    // Redirect while the fetch of 0x8 is outstanding; its ack arrives two cycles later
    doReset();
    tick(); checkCycle("rd c1", 1, 32'h0, 0, 32'h0);
    tick(); checkCycle("rd c2", 1, 32'h4, 1, 32'h0);
    holdAck = 1'b1;
    tick(); checkCycle("rd c3", 1, 32'h8, 1, 32'h4);
    redirect = 1'b1; redirectPc = 32'h100;
    tick(); redirect = 1'b0;
    checkCycle("rd c4", 1, 32'h8, 0, 32'h0);
    holdAck = 1'b0;
    tick(); checkCycle("rd c5", 1, 32'h8, 0, 32'h0);
    tick(); checkCycle("rd c6", 1, 32'h100, 0, 32'h0);
    tick(); checkCycle("rd c7", 1, 32'h104, 1, 32'h100);
    tick(); checkCycle("rd c8", 1, 32'h108, 1, 32'h104);

    // A second redirect while already dropping replaces the restart address
    holdAck = 1'b1;
    tick(); checkCycle("dr c9", 1, 32'h10C, 1, 32'h108);
    redirect = 1'b1; redirectPc = 32'h300;
    tick(); checkCycle("dr c10", 1, 32'h10C, 0, 32'h0);
    redirectPc = 32'h400;
    tick(); redirect = 1'b0;
    checkCycle("dr c11", 1, 32'h10C, 0, 32'h0);
    holdAck = 1'b0;
    tick(); checkCycle("dr c12", 1, 32'h10C, 0, 32'h0);
    tick(); checkCycle("dr c13", 1, 32'h400, 0, 32'h0);
    tick(); checkCycle("dr c14", 1, 32'h404, 1, 32'h400);

    // Redirect coinciding with the ack for 0x10 while two entries are buffered
    doReset();
    tick(); checkCycle("ra c1", 1, 32'h0, 0, 32'h0);
    tick(); checkCycle("ra c2", 1, 32'h4, 1, 32'h0);
    tick(); checkCycle("ra c3", 1, 32'h8, 1, 32'h4);
    tick(); checkCycle("ra c4", 1, 32'hC, 1, 32'h8);
    insReady = 1'b0;
    tick(); checkCycle("ra c5", 1, 32'h10, 1, 32'h8);
    redirect = 1'b1; redirectPc = 32'h200;
    tick(); redirect = 1'b0; insReady = 1'b1;
    checkCycle("ra c6", 0, 32'h10, 0, 32'h0);
    tick(); checkCycle("ra c7", 1, 32'h200, 0, 32'h0);
    tick(); checkCycle("ra c8", 1, 32'h204, 1, 32'h200);

    // One-cycle reset mid-stream, then PC wrap from 0xFFFFFFFC
    doReset();
    tick(); checkCycle("rs c1", 1, 32'h0, 0, 32'h0);
    tick(); checkCycle("rs c2", 1, 32'h4, 1, 32'h0);
    tick(); checkCycle("rs c3", 1, 32'h8, 1, 32'h4);
    reset = 1'b1;
    tick(); reset = 1'b0;
    checkCycle("rs c4", 0, 32'h0, 0, 32'h0);
    tick(); checkCycle("rs c5", 1, 32'h0, 0, 32'h0);
    tick(); checkCycle("rs c6", 1, 32'h4, 1, 32'h0);
    redirect = 1'b1; redirectPc = 32'hFFFF_FFFC;
    tick(); redirect = 1'b0;
    checkCycle("rs c7", 0, 32'h4, 0, 32'h0);
    tick(); checkCycle("rs c8", 1, 32'hFFFF_FFFC, 0, 32'h0);
    tick(); checkCycle("rs c9", 1, 32'h0, 1, 32'hFFFF_FFFC);
    tick(); checkCycle("rs c10", 1, 32'h4, 1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
